// File: rtl/eth_frame_log_arbiter.sv
// Two-source, packet-locked round-robin arbiter merging detector log streams
// into one registered AXI-Stream output, with per-source packet counters.
module eth_frame_log_arbiter #(
    parameter int unsigned C_AXIS_LOG_WIDTH = 64,
    parameter int unsigned C_COUNT_WIDTH    = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,

    input  logic [C_AXIS_LOG_WIDTH-1:0] s_axis_log_a_tdata,
    input  logic                        s_axis_log_a_tlast,
    input  logic                        s_axis_log_a_tvalid,
    output logic                        s_axis_log_a_tready,

    input  logic [C_AXIS_LOG_WIDTH-1:0] s_axis_log_b_tdata,
    input  logic                        s_axis_log_b_tlast,
    input  logic                        s_axis_log_b_tvalid,
    output logic                        s_axis_log_b_tready,

    output logic [C_AXIS_LOG_WIDTH-1:0] m_axis_log_tdata,
    output logic                        m_axis_log_tlast,
    output logic                        m_axis_log_tvalid,
    output logic                        m_axis_log_tdest,
    input  logic                        m_axis_log_tready,

    output logic [C_COUNT_WIDTH-1:0]    pkt_count_a,
    output logic [C_COUNT_WIDTH-1:0]    pkt_count_b,
    output logic                        busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2
    } state_t;

    state_t state;
    logic   last_src;      // source that completed the most recent packet (1 = B)
    logic   out_ready_c;
    logic   accept_a_c;
    logic   accept_b_c;

    // Output register can take a beat when empty or draining this cycle
    always_comb begin
        out_ready_c         = !m_axis_log_tvalid || m_axis_log_tready;
        s_axis_log_a_tready = (state == GRANT_A) && out_ready_c;
        s_axis_log_b_tready = (state == GRANT_B) && out_ready_c;
        accept_a_c          = s_axis_log_a_tready && s_axis_log_a_tvalid;
        accept_b_c          = s_axis_log_b_tready && s_axis_log_b_tvalid;
    end

    // Arbitration FSM: grant on packet boundaries, release on accepted tlast
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            last_src    <= 1'b1;
            busy        <= 1'b0;
            pkt_count_a <= '0;
            pkt_count_b <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable) begin
                        if (s_axis_log_a_tvalid && (!s_axis_log_b_tvalid || last_src)) begin
                            state <= GRANT_A;
                            busy  <= 1'b1;
                        end else if (s_axis_log_b_tvalid) begin
                            state <= GRANT_B;
                            busy  <= 1'b1;
                        end
                    end
                end
                GRANT_A: begin
                    if (accept_a_c && s_axis_log_a_tlast) begin
                        state       <= IDLE;
                        busy        <= 1'b0;
                        last_src    <= 1'b0;
                        pkt_count_a <= pkt_count_a + C_COUNT_WIDTH'(1);
                    end
                end
                GRANT_B: begin
                    if (accept_b_c && s_axis_log_b_tlast) begin
                        state       <= IDLE;
                        busy        <= 1'b0;
                        last_src    <= 1'b1;
                        pkt_count_b <= pkt_count_b + C_COUNT_WIDTH'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Single output register stage; holds while stalled, clears on drain
    always_ff @(posedge clk) begin
        if (rst) begin
            m_axis_log_tvalid <= 1'b0;
            m_axis_log_tdata  <= '0;
            m_axis_log_tlast  <= 1'b0;
            m_axis_log_tdest  <= 1'b0;
        end else if (out_ready_c) begin
            m_axis_log_tvalid <= accept_a_c || accept_b_c;
            if (accept_a_c) begin
                m_axis_log_tdata <= s_axis_log_a_tdata;
                m_axis_log_tlast <= s_axis_log_a_tlast;
                m_axis_log_tdest <= 1'b0;
            end else if (accept_b_c) begin
                m_axis_log_tdata <= s_axis_log_b_tdata;
                m_axis_log_tlast <= s_axis_log_b_tlast;
                m_axis_log_tdest <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_eth_frame_log_arbiter.sv
// Bench for eth_frame_log_arbiter: directed scenarios plus randomized traffic
// scored against per-source packet queues.
module tb_eth_frame_log_arbiter;

    localparam int unsigned DW  = 64;
    localparam int unsigned CW  = 32;
    localparam int unsigned CWW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic [DW-1:0] s_a_tdata, s_b_tdata;
    logic          s_a_tlast, s_a_tvalid, s_a_tready;
    logic          s_b_tlast, s_b_tvalid, s_b_tready;
    logic [DW-1:0] m_tdata;
    logic          m_tlast, m_tvalid, m_tdest, m_tready;
    logic [CW-1:0] pkt_count_a, pkt_count_b;
    logic          busy;

    logic [DW-1:0]  w_tdata;
    logic           w_tlast, w_tvalid, w_tdest, w_a_tready, w_b_tready, w_busy;
    logic [CWW-1:0] w_count_a, w_count_b;

    always #5 clk = ~clk;

    eth_frame_log_arbiter #(.C_AXIS_LOG_WIDTH(DW), .C_COUNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .s_axis_log_a_tdata(s_a_tdata), .s_axis_log_a_tlast(s_a_tlast),
        .s_axis_log_a_tvalid(s_a_tvalid), .s_axis_log_a_tready(s_a_tready),
        .s_axis_log_b_tdata(s_b_tdata), .s_axis_log_b_tlast(s_b_tlast),
        .s_axis_log_b_tvalid(s_b_tvalid), .s_axis_log_b_tready(s_b_tready),
        .m_axis_log_tdata(m_tdata), .m_axis_log_tlast(m_tlast),
        .m_axis_log_tvalid(m_tvalid), .m_axis_log_tdest(m_tdest),
        .m_axis_log_tready(m_tready),
        .pkt_count_a(pkt_count_a), .pkt_count_b(pkt_count_b), .busy(busy)
    );

    // Narrow-counter instance on the same traffic to exercise counter wrap
    eth_frame_log_arbiter #(.C_AXIS_LOG_WIDTH(DW), .C_COUNT_WIDTH(CWW)) dut_w (
        .clk(clk), .rst(rst), .enable(enable),
        .s_axis_log_a_tdata(s_a_tdata), .s_axis_log_a_tlast(s_a_tlast),
        .s_axis_log_a_tvalid(s_a_tvalid), .s_axis_log_a_tready(w_a_tready),
        .s_axis_log_b_tdata(s_b_tdata), .s_axis_log_b_tlast(s_b_tlast),
        .s_axis_log_b_tvalid(s_b_tvalid), .s_axis_log_b_tready(w_b_tready),
        .m_axis_log_tdata(w_tdata), .m_axis_log_tlast(w_tlast),
        .m_axis_log_tvalid(w_tvalid), .m_axis_log_tdest(w_tdest),
        .m_axis_log_tready(m_tready),
        .pkt_count_a(w_count_a), .pkt_count_b(w_count_b), .busy(w_busy)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    beat_t qa[$], qb[$];        // beats still to be offered by each source
    beat_t exp_a[$], exp_b[$];  // beats still expected on the output, per source
    int    out_dest_q[$], out_cyc_q[$], pkt_dest_q[$];

    int checks = 0, errors = 0;
    int cyc = 0, acc_a = 0, pat_idx = 0, rdy_mode = 0, stall_seen = 0;
    int mdl_cnt[2];
    int mdl_last = 1;
    bit gap_a = 0, gap_b = 0, rand_en = 0, b_rdy_seen = 0;
    bit prev_last = 1, prev_dest = 0, held = 0;
    logic [DW-1:0] held_data;
    logic held_last, held_dest;

    task automatic drive();
        if (qa.size() > 0) begin
            s_a_tdata  = qa[0].data;
            s_a_tlast  = qa[0].last;
            s_a_tvalid = !(gap_a && $urandom_range(0, 3) == 0);
        end else begin
            s_a_tdata = '0; s_a_tlast = 1'b0; s_a_tvalid = 1'b0;
        end
        if (qb.size() > 0) begin
            s_b_tdata  = qb[0].data;
            s_b_tlast  = qb[0].last;
            s_b_tvalid = !(gap_b && $urandom_range(0, 3) == 0);
        end else begin
            s_b_tdata = '0; s_b_tlast = 1'b0; s_b_tvalid = 1'b0;
        end
        case (rdy_mode)
            0:       m_tready = 1'b1;
            1:       m_tready = (pat_idx % 3 == 0);
            default: m_tready = 1'($urandom_range(0, 1));
        endcase
        pat_idx++;
        if (rand_en) enable = ($urandom_range(0, 3) != 0);
    endtask

    task automatic add_pkt(input int src, input int len);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.data = {$urandom, $urandom};
            b.last = (i == len - 1);
            if (src == 0) begin qa.push_back(b); exp_a.push_back(b); end
            else          begin qb.push_back(b); exp_b.push_back(b); end
        end
        drive();
    endtask

    // One clock: observe and score at negedge, advance sources after posedge
    task automatic step();
        bit a_hs, b_hs;
        beat_t e;
        @(negedge clk);
        cyc++;
        a_hs = s_a_tvalid && s_a_tready;
        b_hs = s_b_tvalid && s_b_tready;
        if (s_b_tready) b_rdy_seen = 1;
        checks++;
        if (s_a_tready && s_b_tready) begin
            errors++; $display("FAIL both_ready: a_tready=%b b_tready=%b required not both 1", s_a_tready, s_b_tready);
        end
        if (held) begin
            checks++;
            if (m_tvalid !== 1'b1 || m_tdata !== held_data || m_tlast !== held_last || m_tdest !== held_dest) begin
                errors++;
                $display("FAIL stall_hold: got v=%b d=%h l=%b t=%b required v=1 d=%h l=%b t=%b",
                         m_tvalid, m_tdata, m_tlast, m_tdest, held_data, held_last, held_dest);
            end
        end
        if (m_tvalid && m_tready) begin
            checks++;
            if ((m_tdest ? exp_b.size() : exp_a.size()) == 0) begin
                errors++; $display("FAIL spurious_beat: tdest=%b data=%h required no beat", m_tdest, m_tdata);
            end else begin
                e = m_tdest ? exp_b.pop_front() : exp_a.pop_front();
                if (m_tdata !== e.data || m_tlast !== e.last) begin
                    errors++;
                    $display("FAIL out_beat: src=%0d got d=%h l=%b required d=%h l=%b", m_tdest, m_tdata, m_tlast, e.data, e.last);
                end
            end
            checks++;
            if (!prev_last && m_tdest !== prev_dest) begin
                errors++; $display("FAIL interleave: got tdest=%b required %b", m_tdest, prev_dest);
            end
            if (prev_last) pkt_dest_q.push_back(int'(m_tdest));
            prev_last = m_tlast;
            prev_dest = m_tdest;
            if (m_tlast) begin
                mdl_cnt[m_tdest]++;
                mdl_last = int'(m_tdest);
            end
            out_dest_q.push_back(int'(m_tdest));
            out_cyc_q.push_back(cyc);
        end
        held = m_tvalid && !m_tready;
        if (held) stall_seen++;
        held_data = m_tdata; held_last = m_tlast; held_dest = m_tdest;
        @(posedge clk);
        #1;
        if (a_hs) begin void'(qa.pop_front()); acc_a++; end
        if (b_hs) void'(qb.pop_front());
        drive();
    endtask

    task automatic run_until_idle(input int max_cyc);
        int n = 0;
        while (!(qa.size() == 0 && qb.size() == 0 && exp_a.size() == 0 &&
                 exp_b.size() == 0 && m_tvalid === 1'b0) && n < max_cyc) begin
            step();
            n++;
        end
        checks++;
        if (n >= max_cyc) begin
            errors++;
            $display("FAIL drain_timeout: pending a=%0d b=%0d after %0d cycles, required 0", exp_a.size(), exp_b.size(), n);
        end
    endtask

    task automatic check_counts(input string tag);
        checks++;
        if (pkt_count_a !== CW'(mdl_cnt[0]) || pkt_count_b !== CW'(mdl_cnt[1])) begin
            errors++;
            $display("FAIL %s_counts: got a=%0d b=%0d required a=%0d b=%0d", tag, pkt_count_a, pkt_count_b, mdl_cnt[0], mdl_cnt[1]);
        end
        checks++;
        if (w_count_a !== CWW'(mdl_cnt[0] % 4) || w_count_b !== CWW'(mdl_cnt[1] % 4)) begin
            errors++;
            $display("FAIL %s_wrap_counts: got a=%0d b=%0d required a=%0d b=%0d", tag, w_count_a, w_count_b, mdl_cnt[0] % 4, mdl_cnt[1] % 4);
        end
    endtask

    task automatic clear_logs();
        out_dest_q.delete(); out_cyc_q.delete(); pkt_dest_q.delete();
    endtask

    task automatic model_reset();
        mdl_cnt[0] = 0; mdl_cnt[1] = 0; mdl_last = 1;
        prev_last = 1; held = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b1; m_tready = 1'b1;
        s_a_tvalid = 1'b1; s_b_tvalid = 1'b1;
        s_a_tdata = '1; s_b_tdata = '1; s_a_tlast = 1'b0; s_b_tlast = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();
        checks++;
        if (m_tvalid !== 1'b0 || m_tlast !== 1'b0 || m_tdest !== 1'b0 || m_tdata !== '0) begin
            errors++; $display("FAIL reset_out: got v=%b l=%b t=%b d=%h required all 0", m_tvalid, m_tlast, m_tdest, m_tdata);
        end
        checks++;
        if (busy !== 1'b0 || s_a_tready !== 1'b0 || s_b_tready !== 1'b0) begin
            errors++; $display("FAIL reset_ctrl: got busy=%b a_rdy=%b b_rdy=%b required 0 0 0", busy, s_a_tready, s_b_tready);
        end
        check_counts("reset");
        rst = 1'b0;
        s_a_tvalid = 1'b0; s_b_tvalid = 1'b0;
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic test_tie();
        int c0;
        rdy_mode = 0; clear_logs();
        add_pkt(0, 3);
        add_pkt(1, 3);
        c0 = cyc;
        run_until_idle(50);
        checks++;
        if (out_dest_q.size() != 6) begin
            errors++; $display("FAIL tie_beats: got %0d beats required 6", out_dest_q.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (out_dest_q[i] != (i < 3 ? 0 : 1)) begin
                    errors++; $display("FAIL tie_order: beat %0d tdest=%0d required %0d", i, out_dest_q[i], (i < 3 ? 0 : 1));
                end
            end
            checks++;
            if (out_cyc_q[0] != c0 + 3 || out_cyc_q[2] != out_cyc_q[0] + 2 || out_cyc_q[3] != out_cyc_q[2] + 2) begin
                errors++;
                $display("FAIL tie_timing: got first=%0d a3=%0d b1=%0d required %0d %0d %0d",
                         out_cyc_q[0] - c0, out_cyc_q[2] - c0, out_cyc_q[3] - c0, 3, 5, 7);
            end
        end
        check_counts("tie");
    endtask

    task automatic test_back_to_back();
        int first;
        rdy_mode = 0; clear_logs();
        first = 1 - mdl_last;
        for (int i = 0; i < 4; i++) begin add_pkt(0, 2); add_pkt(1, 2); end
        run_until_idle(100);
        checks++;
        if (pkt_dest_q.size() != 8) begin
            errors++; $display("FAIL alt_pkts: got %0d packets required 8", pkt_dest_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (pkt_dest_q[i] != (first ^ (i & 1))) begin
                    errors++; $display("FAIL alt_order: packet %0d tdest=%0d required %0d", i, pkt_dest_q[i], first ^ (i & 1));
                end
            end
        end
        check_counts("alt");
    endtask

    task automatic test_stall();
        rdy_mode = 1; pat_idx = 0; stall_seen = 0; clear_logs();
        add_pkt(1, 4);
        run_until_idle(100);
        checks++;
        if (out_dest_q.size() != 4 || stall_seen == 0) begin
            errors++; $display("FAIL stall_beats: got %0d beats %0d stalls required 4 beats, >0 stalls", out_dest_q.size(), stall_seen);
        end
        rdy_mode = 0;
        check_counts("stall");
    endtask

    task automatic test_enable_drop();
        int n = 0;
        rdy_mode = 0; enable = 1'b1; acc_a = 0;
        add_pkt(0, 5);
        while (acc_a < 2 && n < 20) begin step(); n++; end
        enable = 1'b0;
        checks++;
        if (acc_a != 2 || busy !== 1'b1) begin
            errors++; $display("FAIL en_midpkt: got accepted=%0d busy=%b required 2 1", acc_a, busy);
        end
        add_pkt(1, 2);
        b_rdy_seen = 0;
        repeat (20) step();
        checks++;
        if (exp_a.size() != 0 || exp_b.size() != 2 || b_rdy_seen || busy !== 1'b0) begin
            errors++;
            $display("FAIL en_drop: got a_left=%0d b_left=%0d b_rdy_seen=%0d busy=%b required 0 2 0 0",
                     exp_a.size(), exp_b.size(), b_rdy_seen, busy);
        end
        check_counts("en_drop");
        enable = 1'b1;
        run_until_idle(50);
        check_counts("en_resume");
    endtask

    task automatic test_reset_mid_packet();
        int n = 0;
        rdy_mode = 0; enable = 1'b1; acc_a = 0;
        add_pkt(0, 3);
        while (acc_a < 1 && n < 20) begin step(); n++; end
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_reset();
        void'(exp_a.pop_front());
        checks++;
        if (m_tvalid !== 1'b0 || busy !== 1'b0 || s_a_tready !== 1'b0 || s_b_tready !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid: got v=%b busy=%b a_rdy=%b b_rdy=%b required 0 0 0 0", m_tvalid, busy, s_a_tready, s_b_tready);
        end
        check_counts("rst_mid");
        run_until_idle(50);
        check_counts("rst_remainder");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) add_pkt(int'($urandom_range(0, 1)), int'($urandom_range(1, 5)));
        rdy_mode = 2; gap_a = 1; gap_b = 1; rand_en = 1;
        repeat (300) step();
        rand_en = 0; enable = 1'b1; gap_a = 0; gap_b = 0;
        run_until_idle(4000);
        check_counts("random");
    endtask

    initial begin
        test_reset();
        test_tie();
        test_back_to_back();
        test_stall();
        test_enable_drop();
        test_reset_mid_packet();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
